// File: rtl/control_unit.sv
// control_unit -- instruction sequencer for a basic accumulator machine.
//
// Walks the fetch/decode/execute T-states, decodes the IR latched at the end
// of T2 and emits one-hot datapath and memory strobes for each step.
//
// Ports
//   clk        rising-edge clock
//   i_rst      synchronous active-high reset
//   i_start    begin sequencing from IDLE, or resume from HALT
//   i_ir       datapath IR: [15] I, [14:12] opcode, [11:0] address/register-op
//   i_dr_zero  DR == 0, qualifies the ISZ skip in T6
//   o_*        phase, memory and op-select strobes; o_sc is the T index
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for i_start, all outputs low
// CLR   | one-cycle datapath register clear
// T0    | fetch, address setup
// T1    | fetch, memory read of instruction
// T2    | decode, IR latched at the closing edge
// T3    | register-ref / illegal execute, or indirect address read
// T4    | memory-ref operand access (STA, BUN finish here)
// T5    | ADD/LDA finish, ISZ increment
// T6    | ISZ write-back and conditional skip
// HALT  | stopped after HLT, i_start resumes at T0

module control_unit (
   input  logic        clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [15:0] i_ir,
   input  logic        i_dr_zero,
   output logic        o_clr_reg,
   output logic        o_fetch,
   output logic        o_execute,
   output logic        o_read,
   output logic        o_write,
   output logic        o_is_ind,
   output logic        o_is_dir,
   output logic        o_add,
   output logic        o_load,
   output logic        o_store,
   output logic        o_branch,
   output logic        o_isz,
   output logic        o_clr_ac,
   output logic        o_clr_e,
   output logic        o_comp_ac,
   output logic        o_load_ac,
   output logic        o_cir_r,
   output logic        o_cir_l,
   output logic        o_inc_ac,
   output logic        o_pc_inc,
   output logic        o_ex_done,
   output logic        o_halt,
   output logic        o_illegal,
   output logic [2:0]  o_sc
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLR, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   state_t      state;
   logic        ir_i;
   logic [2:0]  ir_op;
   logic [11:0] ir_fld;

   logic op_ill, op_reg, op_add, op_lda, op_sta, op_bun, op_isz, op_hlt;

   always_comb begin
      op_ill = (ir_op == 3'd0) || (ir_op == 3'd5);
      op_reg = (ir_op == 3'd7);
      op_add = (ir_op == 3'd1);
      op_lda = (ir_op == 3'd2);
      op_sta = (ir_op == 3'd3);
      op_bun = (ir_op == 3'd4);
      op_isz = (ir_op == 3'd6);
      // HLT only when no higher-priority register op bit is set; I/O is a NOP
      op_hlt = op_reg && !ir_i && (ir_fld[11:5] == 7'd0) && ir_fld[0];
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state  <= S_IDLE;
         ir_i   <= 1'b0;
         ir_op  <= 3'd0;
         ir_fld <= 12'd0;
      end else begin
         case (state)
            S_IDLE: if (i_start) state <= S_CLR;
            S_CLR:  state <= S_T0;
            S_T0:   state <= S_T1;
            S_T1:   state <= S_T2;
            S_T2: begin
               ir_i   <= i_ir[15];
               ir_op  <= i_ir[14:12];
               ir_fld <= i_ir[11:0];
               state  <= S_T3;
            end
            S_T3: begin
               if (op_hlt)                state <= S_HALT;
               else if (op_reg || op_ill) state <= S_T0;
               else                       state <= S_T4;
            end
            S_T4:   state <= (op_sta || op_bun) ? S_T0 : S_T5;
            S_T5:   state <= op_isz ? S_T6 : S_T0;
            S_T6:   state <= S_T0;
            S_HALT: if (i_start) state <= S_T0;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_clr_reg = 1'b0; o_fetch  = 1'b0; o_execute = 1'b0; o_read   = 1'b0;
      o_write   = 1'b0; o_is_ind = 1'b0; o_is_dir  = 1'b0; o_add    = 1'b0;
      o_load    = 1'b0; o_store  = 1'b0; o_branch  = 1'b0; o_isz    = 1'b0;
      o_clr_ac  = 1'b0; o_clr_e  = 1'b0; o_comp_ac = 1'b0; o_load_ac = 1'b0;
      o_cir_r   = 1'b0; o_cir_l  = 1'b0; o_inc_ac  = 1'b0; o_pc_inc = 1'b0;
      o_ex_done = 1'b0; o_halt   = 1'b0; o_illegal = 1'b0; o_sc     = 3'd0;
      case (state)
         S_CLR: o_clr_reg = 1'b1;
         S_T0: begin
            o_sc    = 3'd0;
            o_fetch = 1'b1;
         end
         S_T1: begin
            o_sc    = 3'd1;
            o_fetch = 1'b1;
            o_read  = 1'b1;
         end
         S_T2: o_sc = 3'd2;
         S_T3: begin
            o_sc = 3'd3;
            if (op_ill) begin
               o_illegal = 1'b1;
               o_ex_done = 1'b1;
            end else if (op_reg) begin
               o_execute = 1'b1;
               o_ex_done = 1'b1;
               if (!ir_i) begin
                  if      (ir_fld[11]) o_clr_ac  = 1'b1;
                  else if (ir_fld[10]) o_clr_e   = 1'b1;
                  else if (ir_fld[9])  o_comp_ac = 1'b1;
                  else if (ir_fld[8])  o_load_ac = 1'b1;
                  else if (ir_fld[7])  o_cir_r   = 1'b1;
                  else if (ir_fld[6])  o_cir_l   = 1'b1;
                  else if (ir_fld[5])  o_inc_ac  = 1'b1;
               end
            end else if (ir_i) begin
               o_read   = 1'b1;
               o_is_ind = 1'b1;
            end
         end
         S_T4: begin
            o_sc      = 3'd4;
            o_is_dir  = 1'b1;
            o_execute = 1'b1;
            o_read    = op_add || op_lda || op_isz;
            o_write   = op_sta;
            o_add     = op_add;
            o_load    = op_lda;
            o_store   = op_sta;
            o_branch  = op_bun;
            o_isz     = op_isz;
            o_ex_done = op_sta || op_bun;
         end
         S_T5: begin
            o_sc      = 3'd5;
            o_execute = 1'b1;
            o_add     = op_add;
            o_load    = op_lda;
            o_isz     = op_isz;
            o_ex_done = op_add || op_lda;
         end
         S_T6: begin
            o_sc      = 3'd6;
            o_write   = 1'b1;
            o_execute = 1'b1;
            o_isz     = 1'b1;
            o_ex_done = 1'b1;
            o_pc_inc  = i_dr_zero;
         end
         S_HALT: o_halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic [15:0] i_ir = 16'h0;
   logic        i_dr_zero = 1'b0;
   logic o_clr_reg, o_fetch, o_execute, o_read, o_write, o_is_ind, o_is_dir;
   logic o_add, o_load, o_store, o_branch, o_isz;
   logic o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac;
   logic o_pc_inc, o_ex_done, o_halt, o_illegal;
   logic [2:0] o_sc;

   control_unit dut (
      .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_ir(i_ir), .i_dr_zero(i_dr_zero),
      .o_clr_reg(o_clr_reg), .o_fetch(o_fetch), .o_execute(o_execute), .o_read(o_read),
      .o_write(o_write), .o_is_ind(o_is_ind), .o_is_dir(o_is_dir), .o_add(o_add),
      .o_load(o_load), .o_store(o_store), .o_branch(o_branch), .o_isz(o_isz),
      .o_clr_ac(o_clr_ac), .o_clr_e(o_clr_e), .o_comp_ac(o_comp_ac), .o_load_ac(o_load_ac),
      .o_cir_r(o_cir_r), .o_cir_l(o_cir_l), .o_inc_ac(o_inc_ac), .o_pc_inc(o_pc_inc),
      .o_ex_done(o_ex_done), .o_halt(o_halt), .o_illegal(o_illegal), .o_sc(o_sc)
   );

   always #5 clk = ~clk;

   // output word layout: one bit per strobe, T index in [26:24], model flags above
   localparam logic [31:0] B_CLR = 32'h1 << 0,  B_FETCH = 32'h1 << 1,  B_EXE = 32'h1 << 2;
   localparam logic [31:0] B_RD = 32'h1 << 3,   B_WR = 32'h1 << 4,     B_IND = 32'h1 << 5;
   localparam logic [31:0] B_DIR = 32'h1 << 6,  B_ADD = 32'h1 << 7,    B_LOAD = 32'h1 << 8;
   localparam logic [31:0] B_STORE = 32'h1 << 9, B_BR = 32'h1 << 10,   B_ISZ = 32'h1 << 11;
   localparam logic [31:0] B_CLRAC = 32'h1 << 12, B_CLRE = 32'h1 << 13, B_COMP = 32'h1 << 14;
   localparam logic [31:0] B_LDAC = 32'h1 << 15, B_CIRR = 32'h1 << 16, B_CIRL = 32'h1 << 17;
   localparam logic [31:0] B_INC = 32'h1 << 18, B_PCINC = 32'h1 << 19, B_DONE = 32'h1 << 20;
   localparam logic [31:0] B_HALT = 32'h1 << 21, B_ILL = 32'h1 << 22;
   localparam logic [31:0] F_DEC = 32'h1 << 28, F_PC = 32'h1 << 29, F_HLT = 32'h1 << 30;

   function automatic logic [31:0] sc(input int n);
      return 32'(n) << 24;
   endfunction

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // reference model: 0 idle, 1 clear, 2 running an instruction plan, 3 halted
   int mode = 0;
   logic [31:0] plan[$];
   logic [31:0] last_act;
   logic [31:0] acts[0:7];

   function automatic logic [31:0] dut_word();
      return {5'd0, o_sc, 1'b0, o_illegal, o_halt, o_ex_done, o_pc_inc, o_inc_ac,
              o_cir_l, o_cir_r, o_load_ac, o_comp_ac, o_clr_e, o_clr_ac, o_isz,
              o_branch, o_store, o_load, o_add, o_is_dir, o_is_ind, o_write,
              o_read, o_execute, o_fetch, o_clr_reg};
   endfunction

   task automatic push_fetch();
      plan.push_back(B_FETCH | sc(0));
      plan.push_back(B_FETCH | B_RD | sc(1));
      plan.push_back(sc(2) | F_DEC);
   endtask

   // remaining steps of one instruction, derived from the IR seen at decode
   task automatic build(input logic [15:0] ir);
      logic [2:0] op;
      logic [31:0] sel;
      logic [31:0] rsel[0:6];
      op = ir[14:12];
      rsel[0] = B_CLRAC; rsel[1] = B_CLRE; rsel[2] = B_COMP; rsel[3] = B_LDAC;
      rsel[4] = B_CIRR;  rsel[5] = B_CIRL; rsel[6] = B_INC;
      if (op == 3'd0 || op == 3'd5) begin
         plan.push_back(B_ILL | B_DONE | sc(3));
      end else if (op == 3'd7) begin
         sel = 32'h0;
         if (!ir[15]) begin
            for (int k = 0; k < 7; k++)
               if (sel == 32'h0 && ir[11-k]) sel = rsel[k];
            if (sel == 32'h0 && ir[0]) sel = F_HLT;
         end
         plan.push_back(B_EXE | B_DONE | sel | sc(3));
      end else begin
         plan.push_back((ir[15] ? (B_RD | B_IND) : 32'h0) | sc(3));
         case (op)
            3'd1, 3'd2: begin
               sel = (op == 3'd1) ? B_ADD : B_LOAD;
               plan.push_back(B_RD | B_DIR | B_EXE | sel | sc(4));
               plan.push_back(B_EXE | sel | B_DONE | sc(5));
            end
            3'd3: plan.push_back(B_WR | B_DIR | B_EXE | B_STORE | B_DONE | sc(4));
            3'd4: plan.push_back(B_DIR | B_EXE | B_BR | B_DONE | sc(4));
            default: begin
               plan.push_back(B_RD | B_DIR | B_EXE | B_ISZ | sc(4));
               plan.push_back(B_EXE | B_ISZ | sc(5));
               plan.push_back(B_WR | B_EXE | B_ISZ | B_DONE | F_PC | sc(6));
            end
         endcase
      end
   endtask

   function automatic logic [31:0] model_out();
      logic [31:0] e;
      case (mode)
         0: return 32'h0;
         1: return B_CLR;
         3: return B_HALT;
         default: begin
            e = plan[0];
            return (e & 32'h0FFF_FFFF) | (((e & F_PC) != 0 && i_dr_zero) ? B_PCINC : 32'h0);
         end
      endcase
   endfunction

   task automatic model_advance();
      logic [31:0] e;
      if (i_rst) begin
         mode = 0;
         plan.delete();
      end else begin
         case (mode)
            0: if (i_start) mode = 1;
            1: begin mode = 2; push_fetch(); end
            3: if (i_start) begin mode = 2; push_fetch(); end
            default: begin
               e = plan.pop_front();
               if ((e & F_DEC) != 0) build(i_ir);
               if (plan.size() == 0) begin
                  if ((e & F_HLT) != 0) mode = 3;
                  else push_fetch();
               end
            end
         endcase
      end
   endtask

   // one clock cycle: drive, compare against the model, then advance it on the edge
   task automatic step(input logic rst, input logic st, input logic [15:0] ir, input logic dz);
      logic [31:0] exp;
      @(negedge clk);
      i_rst = rst; i_start = st; i_ir = ir; i_dr_zero = dz;
      #1;
      exp = model_out();
      last_act = dut_word();
      tests++;
      if (last_act !== exp) begin
         fails++;
         $display("FAIL model_cmp cyc=%0d ir=%h act=%h exp=%h", cyc, ir, last_act, exp);
      end
      @(posedge clk);
      model_advance();
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic run_instr(input logic [15:0] ir, input logic dz, input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, ir, dz);
         acts[i] = last_act;
      end
   endtask

   logic [15:0] pool[0:15] = '{16'h2005, 16'hB010, 16'h7880, 16'h6020, 16'h7001, 16'h1003,
                               16'h5000, 16'h0FFF, 16'h4ABC, 16'hF001, 16'h7020, 16'h7400,
                               16'h7200, 16'h7100, 16'h7040, 16'hE123};

   initial begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      step(1'b1, 1'b1, 16'h0, 1'b0);
      step(1'b0, 1'b1, 16'h2005, 1'b0);
      chk("reset_idle", last_act, 32'h0);
      step(1'b0, 1'b0, 16'h2005, 1'b0);
      chk("clr_pulse", last_act, B_CLR);
      run_instr(16'h2005, 1'b0, 6);
      for (int i = 0; i < 6; i++) chk("lda_sc", 32'(acts[i][26:24]), 32'(i));
      chk("lda_t4", acts[4], B_RD | B_DIR | B_EXE | B_LOAD | sc(4));
      chk("lda_t5", acts[5], B_EXE | B_LOAD | B_DONE | sc(5));

      run_instr(16'hB010, 1'b0, 5);
      chk("sc_wrap", acts[0], B_FETCH);
      chk("sta_t3", acts[3], B_RD | B_IND | sc(3));
      chk("sta_t4", acts[4], B_WR | B_DIR | B_EXE | B_STORE | B_DONE | sc(4));

      run_instr(16'h7880, 1'b0, 4);
      chk("reg_prio", acts[3], B_CLRAC | B_EXE | B_DONE | sc(3));

      run_instr(16'h6020, 1'b1, 7);
      chk("isz_skip", acts[6], B_WR | B_EXE | B_ISZ | B_DONE | B_PCINC | sc(6));
      run_instr(16'h6020, 1'b0, 7);
      chk("isz_noskip", acts[6], B_WR | B_EXE | B_ISZ | B_DONE | sc(6));

      run_instr(16'h5123, 1'b0, 4);
      chk("illegal", acts[3], B_ILL | B_DONE | sc(3));

      run_instr(16'h7001, 1'b0, 4);
      chk("hlt_t3", acts[3], B_EXE | B_DONE | sc(3));
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("halt_hold", last_act, B_HALT);
      step(1'b0, 1'b1, 16'h1003, 1'b0);
      chk("halt_start", last_act, B_HALT);
      step(1'b0, 1'b0, 16'h1003, 1'b0);
      chk("resume_t0", last_act, B_FETCH);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1003, 1'b0);
      step(1'b1, 1'b1, 16'h1003, 1'b0);
      chk("add_t4", last_act, B_RD | B_DIR | B_EXE | B_ADD | sc(4));
      step(1'b0, 1'b0, 16'h1003, 1'b0);
      chk("rst_abort", last_act, 32'h0);

      for (int n = 0; n < 4000; n++) begin
         logic [15:0] ir;
         ir = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 15)] : 16'($urandom);
         step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, ir, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the clock and i_rst is the reset.
REQ-002 The ports SHALL be, clock and reset first:
  clk          input   1   rising-edge clock
  i_rst        input   1   synchronous active-high reset
  i_start      input   1   begin or resume instruction sequencing
  i_ir         input  16   datapath IR; [15] = I, [14:12] = opcode, [11:0] = address or register-op field
  i_dr_zero    input   1   datapath DR == 0, used during ISZ
  o_clr_reg    output  1   datapath register clear
  o_fetch      output  1   fetch phase (T0, T1)
  o_execute    output  1   execute phase
  o_read       output  1   memory read
  o_write      output  1   memory write
  o_is_ind     output  1   indirect address fetch
  o_is_dir     output  1   direct operand access
  o_add, o_load, o_store, o_branch, o_isz   output  1 each   memory-reference op selects
  o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac   output  1 each   register-reference op selects
  o_pc_inc     output  1   ISZ skip (PC+1)
  o_ex_done    output  1   instruction complete, one-cycle pulse
  o_halt       output  1   halted
  o_illegal    output  1   unsupported opcode, one-cycle pulse
  o_sc         output  3   sequence counter (T index)

Function
REQ-003 States SHALL be IDLE, CLR, T0, T1, T2, T3, T4, T5, T6 and HALT; o_sc SHALL equal the T index and be 0 in IDLE, CLR and HALT.
REQ-004 In IDLE with i_start=1, the block SHALL go to CLR; CLR SHALL assert o_clr_reg for exactly one cycle and then go to T0.
REQ-005 T0: o_fetch=1. T1: o_fetch=1, o_read=1. T2: decode; i_ir SHALL be sampled at the T2 edge, and opcode and I SHALL be latched internally.
REQ-006 Register-reference (opcode 7, I=0): in T3, assert o_execute and exactly one op select, then o_ex_done.
REQ-007 Register-op priority SHALL run highest bit first: [11] clr_ac, [10] clr_e, [9] comp_ac, [8] load_ac, [7] cir_r, [6] cir_l, [5] inc_ac, [0] HLT.
REQ-008 A register-reference instruction with none of bits [11:5] or [0] set SHALL be a NOP, with o_ex_done in T3. I/O (opcode 7, I=1) SHALL be the same NOP.
REQ-009 HLT SHALL assert o_ex_done in T3 and then go to HALT, with o_halt=1 and no other outputs asserted.
REQ-010 Memory-reference with I=1: T3 SHALL assert o_read and o_is_ind. With I=0, T3 SHALL assert nothing.
REQ-011 ADD/LDA (opcode 1/2) SHALL assert in T4 o_read, o_is_dir, o_execute and o_add/o_load, and in T5 o_execute and o_add/o_load, with o_ex_done in T5.
REQ-012 STA (opcode 3) SHALL assert o_write, o_is_dir, o_execute, o_store and o_ex_done in T4.
REQ-013 BUN (opcode 4) SHALL assert o_is_dir, o_execute, o_branch and o_ex_done in T4.
REQ-014 ISZ (opcode 6) SHALL sequence as follows:
  T4: o_read, o_is_dir, o_execute, o_isz.
  T5: o_execute, o_isz.
  T6: o_write, o_execute, o_isz, o_ex_done, and o_pc_inc = i_dr_zero (combinational in T6 only).
REQ-015 Opcodes 0 and 5 SHALL pulse o_illegal and o_ex_done in T3, with no datapath selects.
REQ-016 After o_ex_done, the next state SHALL be T0, or HALT for HLT; o_sc SHALL wrap to 0 with no idle cycle.
REQ-017 In HALT, i_start=1 SHALL go to T0 without CLR. i_start SHALL be ignored in all other states except IDLE.
REQ-018 All outputs SHALL be decoded from registered state and latched opcode only; i_dr_zero in T6 is the only combinational input-to-output path.

Reset
REQ-019 When i_rst=1 at a clock edge, the state SHALL become IDLE and the latched opcode and I SHALL clear.
REQ-020 While in IDLE, every output SHALL be 0, including o_sc=0.
REQ-021 Reset SHALL take precedence over i_start and over any in-flight instruction at any T state.

Verification
REQ-022 Reset, then i_start, with i_ir=0x2005 (LDA, direct) -> o_clr_reg for 1 cycle; T0..T5; o_load=1 in T4 and T5; o_ex_done in T5; o_sc then returns to 0.
REQ-023 i_ir=0xB010 (STA, indirect) -> T3 o_read=1, o_is_ind=1; T4 o_write=1, o_store=1, o_ex_done=1.
REQ-024 i_ir=0x7880 -> only o_clr_ac and o_execute in T3 (o_cir_r stays 0); o_ex_done in T3.
REQ-025 i_ir=0x6020 (ISZ) with i_dr_zero=1 in T6 -> o_pc_inc=1 and o_ex_done in T6; repeat with i_dr_zero=0 -> o_pc_inc=0.
REQ-026 i_ir=0x7001 (HLT) -> o_halt=1 and o_sc=0 held; then i_start -> T0 next cycle with o_clr_reg=0.
REQ-027 Assert i_rst during T4 of ADD (i_ir=0x1003) -> next cycle IDLE with all outputs 0; no o_ex_done.
